// File: rtl/mem_arbiter.sv
// Two-port (data/instruction cache) arbiter onto one line-wide main memory.
// ARB_RR_EN: round-robin on simultaneous requests, else data side wins.
module mem_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         d_rd,
  input  logic         d_wr,
  input  logic [31:0]  d_addr,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_ready,
  output logic         d_busy,
  input  logic         i_rd,
  input  logic         i_wr,
  input  logic [31:0]  i_addr,
  input  logic [127:0] i_wdata,
  output logic [127:0] i_rdata,
  output logic         i_ready,
  output logic         i_busy,
  output logic         mem_oe,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    HOLD
  } state_t;

  state_t         state_q;
  logic           gnt_i_q;
  logic           mem_oe_q;
  logic           mem_we_q;
  logic [31:0]    mem_addr_q;
  logic [127:0]   mem_wdata_q;
  logic [127:0]   d_rdata_q;
  logic [127:0]   i_rdata_q;
  logic           d_ready_q;
  logic           i_ready_q;
  logic           d_busy_q;
  logic           i_busy_q;
`ifdef ARB_RR_EN
  logic           ptr_q;
`endif

  logic           d_req;
  logic           i_req;
  logic           gnt_i_d;
  logic           wr_d;
  logic [31:0]    addr_d;
  logic [127:0]   wdata_d;

  // Pick the side to grant and select its op, line address and write data
  always_comb begin
    d_req   = d_rd | d_wr;
    i_req   = i_rd | i_wr;
`ifdef ARB_RR_EN
    gnt_i_d = i_req & (~d_req | ptr_q);
`else
    gnt_i_d = i_req & ~d_req;
`endif
    wr_d    = gnt_i_d ? i_wr : d_wr;
    addr_d  = (gnt_i_d ? i_addr : d_addr) & 32'hFFFF_FFF0;
    wdata_d = gnt_i_d ? i_wdata : d_wdata;
  end

  // Transaction FSM with all outputs held in registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_i_q     <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      d_rdata_q   <= '0;
      i_rdata_q   <= '0;
      d_ready_q   <= 1'b0;
      i_ready_q   <= 1'b0;
      d_busy_q    <= 1'b0;
      i_busy_q    <= 1'b0;
`ifdef ARB_RR_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      d_ready_q <= 1'b0;
      i_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (d_req | i_req) begin
            state_q     <= ACCESS;
            gnt_i_q     <= gnt_i_d;
            mem_oe_q    <= ~wr_d;
            mem_we_q    <= wr_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            d_busy_q    <= gnt_i_d;
            i_busy_q    <= ~gnt_i_d;
`ifdef ARB_RR_EN
            ptr_q       <= ~gnt_i_d;
`endif
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            state_q  <= RESP;
            mem_oe_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (gnt_i_q) begin
              i_ready_q <= 1'b1;
              if (mem_oe_q) i_rdata_q <= mem_rdata;
            end else begin
              d_ready_q <= 1'b1;
              if (mem_oe_q) d_rdata_q <= mem_rdata;
            end
          end
        end
        RESP: begin
          state_q <= HOLD;
        end
        HOLD: begin
          state_q  <= IDLE;
          d_busy_q <= 1'b0;
          i_busy_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_ready   = d_ready_q;
  assign i_ready   = i_ready_q;
  assign d_busy    = d_busy_q;
  assign i_busy    = i_busy_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a
// transaction-level reference model.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         d_rd, d_wr, i_rd, i_wr;
  logic [31:0]  d_addr, i_addr;
  logic [127:0] d_wdata, i_wdata;
  logic [127:0] d_rdata, i_rdata;
  logic         d_ready, d_busy, i_ready, i_busy;
  logic         mem_oe, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_d = '0;
  logic [127:0] exp_i = '0;
`ifdef ARB_RR_EN
  logic ptr = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_ready(d_ready), .d_busy(d_busy),
    .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_rdata(i_rdata),
    .i_ready(i_ready), .i_busy(i_busy),
    .mem_oe(mem_oe), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drop_req();
    d_rd = 0; d_wr = 0; i_rd = 0; i_wr = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_oe"}, mem_oe, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_drdy"}, d_ready, 0);
    chk({tag, "_irdy"}, i_ready, 0);
    chk({tag, "_dbusy"}, d_busy, 0);
    chk({tag, "_ibusy"}, i_busy, 0);
  endtask

  // mode 0: drop after ready, 1: hold one extra cycle, 2: drop after grant
  task automatic txn(input logic dr, dw, ir, iw,
                     input logic [31:0] da, ia,
                     input logic [127:0] dwd, iwd, rdv,
                     input int lat, input int mode,
                     output logic obs_i);
    logic dq, iq, gi, wr;
    logic [31:0] ea;
    logic [127:0] ew;
    dq = dr | dw;
    iq = ir | iw;
`ifdef ARB_RR_EN
    gi = iq && (!dq || ptr);
    ptr = !gi;
`else
    gi = iq && !dq;
`endif
    wr = gi ? iw : dw;
    ea = (gi ? ia : da) & 32'hFFFF_FFF0;
    ew = gi ? iwd : dwd;
    @(posedge clk); #1;
    d_rd = dr; d_wr = dw; d_addr = da; d_wdata = dwd;
    i_rd = ir; i_wr = iw; i_addr = ia; i_wdata = iwd;
    @(posedge clk);
    @(negedge clk);
    obs_i = d_busy;
    chk("acc_oe", mem_oe, !wr);
    chk("acc_we", mem_we, wr);
    chk("acc_addr", mem_addr, ea);
    if (wr) chk("acc_wdata", mem_wdata, ew);
    chk("acc_dbusy", d_busy, gi);
    chk("acc_ibusy", i_busy, !gi);
    chk("acc_rdy", {d_ready, i_ready}, 0);
    if (mode == 2) drop_req();
    for (int k = 0; k < lat; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("wait_oe", mem_oe, !wr);
      chk("wait_we", mem_we, wr);
      chk("wait_addr", mem_addr, ea);
      chk("wait_rdy", {d_ready, i_ready}, 0);
    end
    mem_ready = 1;
    mem_rdata = rdv;
    @(posedge clk); #1;
    mem_ready = 0;
    mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (!wr) begin
      if (gi) exp_i = rdv;
      else exp_d = rdv;
    end
    @(negedge clk);
    chk("resp_drdy", d_ready, !gi);
    chk("resp_irdy", i_ready, gi);
    chk("resp_oewe", {mem_oe, mem_we}, 0);
    chk("resp_drdata", d_rdata, exp_d);
    chk("resp_irdata", i_rdata, exp_i);
    chk("resp_dbusy", d_busy, gi);
    chk("resp_ibusy", i_busy, !gi);
    @(posedge clk);
    if (mode == 0) begin #1; drop_req(); end
    @(negedge clk);
    chk("hold_rdy", {d_ready, i_ready}, 0);
    chk("hold_oewe", {mem_oe, mem_we}, 0);
    chk("hold_busy", {d_busy, i_busy}, {gi, !gi});
    @(posedge clk);
    if (mode == 1) begin #1; drop_req(); end
    @(negedge clk);
    chk_idle("idle");
    @(posedge clk);
    @(negedge clk);
    chk_idle("nostale");
    chk("end_drdata", d_rdata, exp_d);
    chk("end_irdata", i_rdata, exp_i);
  endtask

  initial begin
    logic g;
    logic [2:0] seq;
    logic [2:0] seq_exp;
    logic [3:0] rq;
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    reset = 1; drop_req();
    d_addr = '0; i_addr = '0; d_wdata = '0; i_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    @(posedge clk); @(negedge clk);
    chk_idle("rst");
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_drdata", d_rdata, 0);
    chk("rst_irdata", i_rdata, 0);
    @(posedge clk); #1; reset = 0;

    txn(1, 0, 0, 0, 32'h0000_1234, 0, 0, 0, a5, 3, 0, g);
    chk("r20_drdata", d_rdata, a5);

    txn(1, 1, 0, 0, 32'h0000_5678, 0,
        128'h1111_2222_3333_4444_5555_6666_7777_8888,
        0, 128'hDEAD, 1, 0, g);
    chk("r21_drdata_kept", d_rdata, a5);

    @(posedge clk); #1;
    i_rd = 1; i_addr = 32'h0000_9ABC;
    @(posedge clk); @(negedge clk);
    chk("r23_oe", mem_oe, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0; drop_req();
    @(negedge clk);
    chk_idle("r23");
    chk("r23_addr", mem_addr, 0);
    chk("r23_rdata", {d_rdata, i_rdata}, 0);
    exp_d = '0; exp_i = '0;
`ifdef ARB_RR_EN
    ptr = 1'b0;
`endif
    mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("r23_quiet", {i_ready, mem_oe, i_busy}, 0);
    end
    mem_ready = 0;

    seq = '0;
    for (int k = 0; k < 3; k++) begin
      txn(1, 0, 1, 0, 32'h100 * k, 32'h2000 + k, 0, 0,
          {4{$urandom}}, 1, 0, g);
      seq[k] = g;
    end
`ifdef ARB_RR_EN
    seq_exp = 3'b010;
`else
    seq_exp = 3'b000;
`endif
    chk("r22_seq", seq, seq_exp);

    txn(0, 0, 1, 0, 0, 32'h0000_4440, 0, 0,
        {4{$urandom}}, 2, 2, g);
    txn(1, 0, 0, 0, 32'h0000_7777, 0, 0, 0,
        {4{$urandom}}, 0, 1, g);

    for (int n = 0; n < 40; n++) begin
      rq = 4'($urandom_range(1, 15));
      txn(rq[3], rq[2], rq[1], rq[0], $urandom, $urandom,
          {4{$urandom}}, {4{$urandom}}, {4{$urandom}},
          $urandom_range(0, 4), $urandom_range(0, 2), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
